liang_issue_queue: RTL and testbench

In-order issue scheduler between decode and the execution units of the single-cycle-to-pipelined core. It buffers decoded `liang_pkg::uop_info_t` micro-ops in a circular queue and tracks pending register writes in a 32-entry scoreboard. It issues the head uop to the ALU or LSU only when its source and destination registers are hazard-free. The queue uses `utils::ptr_t`-style flag/value pointers.

---
 rtl/liang_issue_queue.sv | 93 +++++++++
 tb/tb_liang_issue_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/liang_issue_queue.sv
// liang_issue_queue: in-order issue queue with a 32-entry register scoreboard, routing head uops to ALU or LSU.
`timescale 1ns/1ps
package liang_pkg;
    typedef enum logic [1:0] {FU_NONE, FU_ALU, FU_LSU, FU_MFPU} fu_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_ALR, OP_ALI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
    } fu_op_t;
    typedef struct packed {
        fu_t         fu;
        fu_op_t      fu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] imm;
    } uop_info_t;
endpackage

module liang_issue_queue
    import liang_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enq_valid_i,
    output logic            enq_ready_o,
    input  uop_info_t       enq_uop_i,
    output uop_info_t       iss_uop_o,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output logic            lsu_valid_o,
    input  logic            lsu_ready_i,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic            flush_i,
    output logic            drop_o,
    output logic [PW:0]     count_o
);
    logic [PW:0] head_q, head_d, tail_q, tail_d;
    logic [31:0] busy_q, busy_d;
    uop_info_t   mem_q [DEPTH];
    uop_info_t   head;
    logic        empty, full, live, use1, use2, hazard, push, pop, issue;

    assign head  = mem_q[head_q[PW-1:0]];
    assign empty = head_q == tail_q;
    assign full  = (head_q[PW-1:0] == tail_q[PW-1:0]) && (head_q[PW] != tail_q[PW]);
    assign live  = !empty && !flush_i;

    assign use1 = head.fu_op inside {OP_ALR, OP_BRANCH, OP_STORE, OP_ALI, OP_LOAD, OP_JALR};
    assign use2 = head.fu_op inside {OP_ALR, OP_BRANCH, OP_STORE};
    assign hazard = (use1 && busy_q[head.rs1]) || (use2 && busy_q[head.rs2]) ||
                    (head.rd_wen && busy_q[head.rd]);

    assign alu_valid_o = live && !hazard && head.fu == FU_ALU;
    assign lsu_valid_o = live && !hazard && head.fu == FU_LSU;
    assign drop_o      = live && (head.fu inside {FU_NONE, FU_MFPU});
    assign iss_uop_o   = head;
    assign enq_ready_o = !full;
    assign count_o     = {tail_q[PW] ^ head_q[PW], tail_q[PW-1:0]} - {1'b0, head_q[PW-1:0]};

    assign issue = (alu_valid_o && alu_ready_i) || (lsu_valid_o && lsu_ready_i);
    assign pop   = issue || drop_o;
    assign push  = enq_valid_i && !full && !flush_i;

    // {flag,value} increment: carry out of the value field toggles the flag on wrap
    assign head_d = flush_i ? '0 : head_q + (PW+1)'(pop);
    assign tail_d = flush_i ? '0 : tail_q + (PW+1)'(push);

    // set applied after clear so a new producer wins over a same-cycle writeback
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
        if (issue && head.rd_wen) busy_d[head.rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            busy_q <= busy_d;
            if (push) mem_q[tail_q[PW-1:0]] <= enq_uop_i;
        end
    end
endmodule

// File: tb/tb_liang_issue_queue.sv
// tb_liang_issue_queue: directed self-checking bench for liang_issue_queue.
`timescale 1ns/1ps
module tb_liang_issue_queue;
    import liang_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enq_valid_i, alu_ready_i, lsu_ready_i, wb_valid_i, flush_i;
    logic [4:0] wb_rd_i;
    uop_info_t  enq_uop_i, iss_uop_o;
    logic       enq_ready_o, alu_valid_o, lsu_valid_o, drop_o;
    logic [2:0] count_o;

    int n_chk = 0;
    int n_pass = 0;

    liang_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_uop_i(enq_uop_i),
        .iss_uop_o(iss_uop_o),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .flush_i(flush_i), .drop_o(drop_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_chk);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic uop_info_t mk(fu_t f, fu_op_t o, logic [4:0] rd, logic [4:0] rs1,
                                     logic [4:0] rs2, logic w, logic [31:0] imm);
        uop_info_t u;
        u.fu = f; u.fu_op = o; u.rd = rd; u.rs1 = rs1; u.rs2 = rs2; u.rd_wen = w; u.imm = imm;
        return u;
    endfunction

    initial begin
        uop_info_t  u;
        logic [31:0] exp_q[$];
        int sent, popped, toggles, maxc;
        logic prev_flag, do_push, do_pop;
        rst_n = 1'b0; enq_valid_i = 0; alu_ready_i = 0; lsu_ready_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; flush_i = 0; enq_uop_i = '0;
        @(negedge clk);
        check("rst_enq_ready", enq_ready_o, 1);
        check("rst_alu_valid", alu_valid_o, 0);
        check("rst_lsu_valid", lsu_valid_o, 0);
        check("rst_drop", drop_o, 0);
        check("rst_count", count_o, 0);
        check("rst_iss_uop", iss_uop_o, 0);
        check("rst_busy", dut.busy_q, 0);
        rst_n = 1'b1;
        // fill with 4 independent ALI uops, ALU stalled
        for (int i = 1; i <= 4; i++) begin
            enq_valid_i = 1; enq_uop_i = mk(FU_ALU, OP_ALI, 5'(i), 0, 0, 1, 32'(i));
            step();
        end
        check("fill_count", count_o, 4);
        check("fill_enq_ready", enq_ready_o, 0);
        check("fill_alu_valid", alu_valid_o, 1);
        enq_uop_i = mk(FU_ALU, OP_ALI, 9, 0, 0, 1, 99);
        step();
        enq_valid_i = 0;
        check("fifth_rejected_count", count_o, 4);
        alu_ready_i = 1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", alu_valid_o, 1);
            check("drain_rd", iss_uop_o.rd, i);
            step();
        end
        check("drain_count", count_o, 0);
        // RAW hazard on x5
        enq_valid_i = 1; enq_uop_i = mk(FU_ALU, OP_ALI, 5, 0, 0, 1, 0);
        step();
        check("raw_producer_valid", alu_valid_o, 1);
        enq_uop_i = mk(FU_ALU, OP_ALR, 10, 5, 6, 1, 0);
        step();
        enq_valid_i = 0;
        check("raw_blocked0", alu_valid_o, 0);
        check("raw_head_op", iss_uop_o.fu_op, OP_ALR);
        step();
        check("raw_blocked1", alu_valid_o, 0);
        wb_valid_i = 1; wb_rd_i = 5;
        #1 check("raw_no_same_cycle_wake", alu_valid_o, 0);
        step();
        wb_valid_i = 0;
        check("raw_wake", alu_valid_o, 1);
        step();
        check("raw_issued_count", count_o, 0);
        // routing and drop
        alu_ready_i = 0; lsu_ready_i = 0; enq_valid_i = 1;
        enq_uop_i = mk(FU_LSU, OP_LOAD, 7, 0, 0, 1, 0);  step();
        enq_uop_i = mk(FU_NONE, OP_NONE, 0, 0, 0, 0, 0); step();
        enq_uop_i = mk(FU_MFPU, OP_NONE, 0, 0, 0, 0, 0); step();
        enq_valid_i = 0;
        check("route_count", count_o, 3);
        check("route_lsu_valid", lsu_valid_o, 1);
        check("route_alu_valid", alu_valid_o, 0);
        check("route_drop_held", drop_o, 0);
        step();
        check("route_lsu_hold", lsu_valid_o, 1);
        check("route_lsu_rd", iss_uop_o.rd, 7);
        lsu_ready_i = 1;
        step();
        lsu_ready_i = 0;
        check("drop_pulse0", drop_o, 1);
        check("drop_count0", count_o, 2);
        step();
        check("drop_pulse1", drop_o, 1);
        check("drop_count1", count_o, 1);
        step();
        check("drop_end", drop_o, 0);
        check("drop_count2", count_o, 0);
        check("busy7", dut.busy_q[7], 1);
        // wrap-around with random ALU ready
        sent = 0; popped = 0; toggles = 0; maxc = 0; prev_flag = dut.head_q[2];
        for (int cyc = 0; cyc < 400 && popped < 10; cyc++) begin
            enq_valid_i = sent < 10;
            enq_uop_i = mk(FU_ALU, OP_ALI, 0, 0, 0, 0, 32'(100 + sent));
            alu_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (int'(count_o) > maxc) maxc = int'(count_o);
            do_push = enq_valid_i && enq_ready_o;
            do_pop  = alu_valid_o && alu_ready_i;
            if (do_pop) begin
                check("wrap_fifo_order", iss_uop_o.imm, exp_q.pop_front());
                popped++;
            end
            if (do_push) begin
                exp_q.push_back(32'(100 + sent));
                sent++;
            end
            step();
            if (dut.head_q[2] != prev_flag) toggles++;
            prev_flag = dut.head_q[2];
        end
        enq_valid_i = 0; alu_ready_i = 0;
        check("wrap_popped", popped, 10);
        check("wrap_flag_toggles", toggles, 2);
        check("wrap_max_count_le4", maxc <= 4, 1);
        // flush
        enq_valid_i = 1;
        enq_uop_i = mk(FU_ALU, OP_ALI, 11, 0, 0, 1, 0); step();
        enq_uop_i = mk(FU_ALU, OP_ALR, 12, 3, 3, 1, 0); step();
        enq_uop_i = mk(FU_ALU, OP_ALR, 13, 3, 0, 1, 0); step();
        check("flush_pre_count", count_o, 3);
        check("flush_pre_busy3", dut.busy_q[3], 1);
        check("flush_pre_valid", alu_valid_o, 1);
        flush_i = 1; enq_uop_i = mk(FU_ALU, OP_ALI, 14, 0, 0, 1, 0);
        #1 check("flush_valid_forced_low", alu_valid_o, 0);
        step();
        flush_i = 0; enq_valid_i = 0;
        check("flush_count", count_o, 0);
        check("flush_enq_ready", enq_ready_o, 1);
        check("flush_busy3_kept", dut.busy_q[3], 1);
        check("flush_head_ptr", dut.head_q, 0);
        // simultaneous set and clear on x8, then x0 write
        alu_ready_i = 1; enq_valid_i = 1;
        enq_uop_i = mk(FU_ALU, OP_ALI, 8, 0, 0, 1, 0);
        step();
        enq_valid_i = 0;
        check("setclr_valid", alu_valid_o, 1);
        wb_valid_i = 1; wb_rd_i = 8;
        step();
        wb_valid_i = 0;
        check("setclr_busy8", dut.busy_q[8], 1);
        enq_valid_i = 1; enq_uop_i = mk(FU_ALU, OP_ALI, 0, 0, 0, 1, 0);
        step();
        enq_valid_i = 0;
        check("x0_valid", alu_valid_o, 1);
        step();
        check("x0_busy", dut.busy_q[0], 0);
        check("x0_count", count_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
